rom_stream: RTL
===============

ROM_STREAM -- requirements
Module: rom_stream

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 Parameter DEPTH, default 256, number of words; legal range 1..2^ADDR_WIDTH.
REQ-004 Parameter LEN_WIDTH, default 4, burst length field width; beats per burst = req_len+1.
REQ-005 Parameter INIT_FILE, default "" (empty string), hex image loaded at elaboration; when empty: word 0 = 32'hDEADBEEF, word 1 = 32'h12345678, word 2 = 32'hABCDEF01, word i (i>=3) = i zero-extended.
REQ-006 One clock; reset is asynchronous and active-high. Ports: clk  input  1  clock, all logic on rising edge; rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  1  burst request valid.
REQ-008 req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-009 req_addr  input  ADDR_WIDTH  start address.
REQ-010 req_len  input  LEN_WIDTH  beats minus one.
REQ-011 req_fixed  input  1  0 = incrementing burst, 1 = fixed-address burst.
REQ-012 rd_valid  output  1  rd_data/rd_last/rd_err valid.
REQ-013 rd_ready  input  1  consumer accepts the beat when rd_valid and rd_ready are both high.
REQ-014 rd_data  output  DATA_WIDTH  read word.
REQ-015 rd_last  output  1  final beat of the burst.
REQ-016 rd_err  output  1  beat address >= DEPTH.
REQ-017 busy  output  1  high while in BURST or output buffer non-empty.

Function
REQ-018 States IDLE and BURST; IDLE->BURST on request handshake; BURST->IDLE in the cycle the final beat's ROM read is issued.
REQ-019 req_ready = 1 in IDLE only; captured addr/len/mode held internally; inputs ignored in BURST.
REQ-020 ROM read latency is 1 cycle into a 2-entry output FIFO; a read issues only when FIFO occupancy + in-flight reads < 2 (credit rule); no beat is ever dropped or duplicated.
REQ-021 With rd_ready held high, first rd_valid in the 2nd cycle after the request handshake; one beat per cycle thereafter; a burst of N beats completes in N+1 cycles after handshake.
REQ-022 rd_ready low: rd_valid, rd_data, rd_last, rd_err hold stable until accepted; reads stall via credits.
REQ-023 Incrementing mode: beat k address = (req_addr + k) mod 2^ADDR_WIDTH (wrap-around, no error from wrap itself).
REQ-024 Fixed mode: every beat reads req_addr.
REQ-025 Beat address >= DEPTH: rd_data = 0, rd_err = 1 for that beat only; burst continues.
REQ-026 rd_last = 1 exactly on beat req_len; req_len = 0 gives a single beat with rd_last = 1.
REQ-027 Back-to-back requests: a new request may be accepted in the cycle after BURST->IDLE while earlier beats remain in the FIFO; output order is strictly request order.
REQ-028 rd_data = 0 whenever rd_valid = 0; outputs are never high-impedance.
REQ-029 ROM contents are read-only; no write path.

Reset
REQ-030 rst high asynchronously forces state IDLE, FIFO empty, in-flight read discarded, rd_valid 0, rd_data 0, rd_last 0, rd_err 0, busy 0, req_ready 0.
REQ-031 req_ready rises in the first cycle after rst deasserts; rst mid-burst abandons the burst with no further beats.

Structure
REQ-032 Package rom_stream_pkg holds the state enum (IDLE, BURST) and the mode constants MODE_INCR = 0, MODE_FIXED = 1.
REQ-033 Sub-module rom_stream_fifo: 2-entry synchronous FIFO, width DATA_WIDTH+2 (data, last, err), same clk/rst.
REQ-034 ROM array, address generator, beat counter, and credit counter reside in rom_stream.

Verification
REQ-035 Reset then addr=0, len=2, incr, rd_ready=1 -> DEADBEEF, 12345678, ABCDEF01 on consecutive cycles from 2nd cycle after handshake; rd_last on third.
REQ-036 addr=8'hFE, len=3, incr, DEPTH=256 -> words 0xFE, 0xFF, DEADBEEF, 12345678; rd_err never set.
REQ-037 DEPTH=200, addr=198, len=3, incr -> 198, 199, then 0/rd_err=1 twice, rd_last on 4th.
REQ-038 addr=5, len=3, fixed, rd_ready toggled 1-0-0-1... -> four beats of 5, each held stable while rd_ready low, no loss or repeat.
REQ-039 Two requests (addr=0 len=0; addr=10 len=1) back-to-back -> DEADBEEF(last), 10, 11(last) in order.
REQ-040 rst asserted 1 cycle after burst's first rd_valid -> all outputs 0 immediately; after release req_ready=1 and no residual beats.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared types and constants for the ROM burst streamer.
// Holds the burst FSM state enum, burst mode codes and default ROM words.
package rom_stream_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam logic MODE_INCR  = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   localparam logic [31:0] ROM_W0 = 32'hDEADBEEF;
   localparam logic [31:0] ROM_W1 = 32'h12345678;
   localparam logic [31:0] ROM_W2 = 32'hABCDEF01;

endpackage

// File: rtl/rom_stream_fifo.sv
// rom_stream_fifo: 2-entry synchronous FIFO holding {data, last, err} beats.
// Ports: clk, rst (async high), i_push/i_din, i_pop, o_valid/o_dout.
module rom_stream_fifo #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic         o_valid,
   output logic [W-1:0] o_dout
);

   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = i_pop && (r_cnt != 2'd0);
   assign w_push = i_push && (r_cnt != 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_push) r_wp <= ~r_wp;
         if (w_pop)  r_rp <= ~r_rp;
         r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      end
   end

   // Storage needs no reset: the output is gated by occupancy.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end

   assign o_valid = (r_cnt != 2'd0);
   assign o_dout  = o_valid ? r_mem[r_rp] : '0;

endmodule

// File: rtl/rom_stream.sv
// rom_stream: read-only ROM with a valid/ready burst request port and a
// valid/ready beat output. Ports: clk, rst (async high), req_* request
// (addr, len = beats-1, fixed mode), rd_* beat stream (data/last/err), busy.
module rom_stream
   import rom_stream_pkg::*;
#(
   parameter int    ADDR_WIDTH = 8,
   parameter int    DATA_WIDTH = 32,
   parameter int    DEPTH      = 256,
   parameter int    LEN_WIDTH  = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  req_fixed,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rd_err,
   output logic                  busy
);

   localparam int FW = DATA_WIDTH + 2;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   function automatic logic [DATA_WIDTH-1:0] dflt_word(
      input logic [ADDR_WIDTH-1:0] a
   );
      logic [DATA_WIDTH-1:0] w;
      w = DATA_WIDTH'(a);
      if (a == ADDR_WIDTH'(0)) w = DATA_WIDTH'(ROM_W0);
      else if (a == ADDR_WIDTH'(1)) w = DATA_WIDTH'(ROM_W1);
      else if (a == ADDR_WIDTH'(2)) w = DATA_WIDTH'(ROM_W2);
      return w;
   endfunction

   state_t                r_state;
   logic                  r_req_ready;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_beat;
   logic                  r_fixed;
   logic [1:0]            r_credit;

   logic                  w_issue;
   logic                  w_last_issue;
   logic                  w_err;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_word;
   logic [FW-1:0]         w_din;
   logic [FW-1:0]         w_dout;
   logic                  w_fvalid;

   assign w_word = dflt_word(r_addr);

   // A credit is one free FIFO slot not yet claimed by an issued read;
   // the read issued this cycle lands in the FIFO at the next edge.
   assign w_issue      = (r_state == BURST) && (r_credit != 2'd0);
   assign w_last_issue = w_issue && (r_beat == r_len);
   assign w_err        = ({1'b0, r_addr} >= DEPTH_W);
   assign w_pop        = w_fvalid && rd_ready;
   assign w_din        = {(w_err ? '0 : w_word), w_last_issue, w_err};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b0;
         r_addr      <= '0;
         r_len       <= '0;
         r_beat      <= '0;
         r_fixed     <= MODE_INCR;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_addr      <= req_addr;
                  r_len       <= req_len;
                  r_beat      <= '0;
                  r_fixed     <= req_fixed ? MODE_FIXED : MODE_INCR;
                  r_state     <= BURST;
                  r_req_ready <= 1'b0;
               end
            end
            BURST: begin
               if (w_issue) begin
                  r_beat <= r_beat + 1'b1;
                  if (r_fixed == MODE_INCR) r_addr <= r_addr + 1'b1;
                  if (w_last_issue) begin
                     r_state     <= IDLE;
                     r_req_ready <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_credit <= 2'd2;
      else     r_credit <= r_credit - 2'(w_issue) + 2'(w_pop);
   end

   rom_stream_fifo #(.W(FW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_issue),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_valid (w_fvalid),
      .o_dout  (w_dout)
   );

   assign req_ready = r_req_ready;
   assign rd_valid  = w_fvalid;
   assign rd_data   = w_dout[FW-1:2];
   assign rd_last   = w_dout[1];
   assign rd_err    = w_dout[0];
   assign busy      = (r_state == BURST) || w_fvalid;

endmodule
